// File: rtl/bfly_r2_stage_if.sv
// Streaming bus for the radix-2 butterfly stage: input beats with frame
// sync in one direction, sum/difference pairs and status in the other.
interface bfly_r2_stage_if #(
    parameter int IN_WIDTH = 9,
    parameter int NUM      = 16,
    parameter int SCALE    = 0
);
    localparam int OW = IN_WIDTH + 1 - SCALE;

    logic                           valid_in;
    logic                           sof_in;
    logic [NUM-1:0][IN_WIDTH-1:0]   din_i;
    logic [NUM-1:0][IN_WIDTH-1:0]   din_q;
    logic [NUM-1:0][OW-1:0]         do1_re;
    logic [NUM-1:0][OW-1:0]         do1_im;
    logic [NUM-1:0][OW-1:0]         do2_re;
    logic [NUM-1:0][OW-1:0]         do2_im;
    logic                           valid_out;
    logic                           sof_out;
    logic                           err_sync;

    modport master (
        output valid_in, sof_in, din_i, din_q,
        input  do1_re, do1_im, do2_re, do2_im, valid_out, sof_out, err_sync
    );

    modport slave (
        input  valid_in, sof_in, din_i, din_q,
        output do1_re, do1_im, do2_re, do2_im, valid_out, sof_out, err_sync
    );
endinterface

// File: rtl/bfly_r2_stage.sv
// Radix-2 DIF butterfly stage. The first half of every frame is parked in a
// small buffer; each beat of the second half is combined lane by lane with
// the matching buffered beat to produce registered sum/difference pairs.
module bfly_r2_stage #(
    parameter int IN_WIDTH = 9,
    parameter int NUM      = 16,
    parameter int DATA     = 512,
    parameter int SCALE    = 0
) (
    input  logic          clk,
    input  logic          rstn,
    bfly_r2_stage_if.slave bus
);
    localparam int COUNT = DATA / NUM;
    localparam int HALF  = COUNT / 2;
    localparam int OW    = IN_WIDTH + 1 - SCALE;
    localparam int W     = IN_WIDTH + 2;
    localparam int CW    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int KW    = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0]        HALF_C = CW'(HALF);
    localparam logic [CW-1:0]        LAST_C = CW'(COUNT - 1);
    localparam logic signed [W-1:0]  ONE    = W'(1);
    localparam logic signed [W-1:0]  MAXV   = W'((1 << (IN_WIDTH - 1)) - 1);
    localparam logic signed [W-1:0]  MINV   = -W'(1 << (IN_WIDTH - 1));

    typedef logic [NUM-1:0][IN_WIDTH-1:0] beat_t;
    typedef logic [NUM-1:0][OW-1:0]       res_t;

    beat_t           buf_re_q [HALF];
    beat_t           buf_im_q [HALF];

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   eff_cnt;
    logic            wr_en;
    logic [KW-1:0]   wr_slot;
    logic [KW-1:0]   rd_slot;
    beat_t           a_re, a_im;

    logic            valid_out_q, valid_out_d;
    logic            sof_out_q, sof_out_d;
    logic            err_sync_q, err_sync_d;
    res_t            do1_re_q, do1_re_d;
    res_t            do1_im_q, do1_im_d;
    res_t            do2_re_q, do2_re_d;
    res_t            do2_im_q, do2_im_d;

    // One lane/component of the butterfly: exact sum or difference at two
    // guard bits, optionally halved with rounding and clamped to input range.
    function automatic logic [OW-1:0] bfly_op(
        input logic [IN_WIDTH-1:0] a,
        input logic [IN_WIDTH-1:0] b,
        input logic                sub
    );
        logic signed [W-1:0] ea, eb, s, t;
        ea = $signed({{2{a[IN_WIDTH-1]}}, a});
        eb = $signed({{2{b[IN_WIDTH-1]}}, b});
        s  = sub ? (ea - eb) : (ea + eb);
        t  = (s + ONE) >>> 1;
        if (SCALE == 0)
            return s[OW-1:0];
        else if (t > MAXV)
            return MAXV[OW-1:0];
        else if (t < MINV)
            return MINV[OW-1:0];
        else
            return t[OW-1:0];
    endfunction

    // Beat sequencing, frame resync and butterfly evaluation for the next edge.
    always_comb begin
        cnt_d       = cnt_q;
        valid_out_d = 1'b0;
        sof_out_d   = 1'b0;
        err_sync_d  = 1'b0;
        do1_re_d    = do1_re_q;
        do1_im_d    = do1_im_q;
        do2_re_d    = do2_re_q;
        do2_im_d    = do2_im_q;
        wr_en       = 1'b0;
        eff_cnt     = bus.sof_in ? '0 : cnt_q;
        wr_slot     = KW'(eff_cnt);
        rd_slot     = KW'(eff_cnt - HALF_C);
        a_re        = buf_re_q[rd_slot];
        a_im        = buf_im_q[rd_slot];

        if (bus.valid_in) begin
            err_sync_d = bus.sof_in && (cnt_q != '0);
            cnt_d      = (eff_cnt == LAST_C) ? '0 : eff_cnt + 1'b1;
            if (eff_cnt < HALF_C) begin
                wr_en = 1'b1;
            end else begin
                valid_out_d = 1'b1;
                sof_out_d   = (rd_slot == '0);
                for (int j = 0; j < NUM; j++) begin
                    do1_re_d[j] = bfly_op(a_re[j], bus.din_i[j], 1'b0);
                    do1_im_d[j] = bfly_op(a_im[j], bus.din_q[j], 1'b0);
                    do2_re_d[j] = bfly_op(a_re[j], bus.din_i[j], 1'b1);
                    do2_im_d[j] = bfly_op(a_im[j], bus.din_q[j], 1'b1);
                end
            end
        end
    end

    // Counter and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q       <= '0;
            valid_out_q <= 1'b0;
            sof_out_q   <= 1'b0;
            err_sync_q  <= 1'b0;
            do1_re_q    <= '0;
            do1_im_q    <= '0;
            do2_re_q    <= '0;
            do2_im_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            valid_out_q <= valid_out_d;
            sof_out_q   <= sof_out_d;
            err_sync_q  <= err_sync_d;
            do1_re_q    <= do1_re_d;
            do1_im_q    <= do1_im_d;
            do2_re_q    <= do2_re_d;
            do2_im_q    <= do2_im_d;
        end
    end

    // First-half buffer; contents are never cleared since they are always rewritten before use.
    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            buf_re_q[wr_slot] <= bus.din_i;
            buf_im_q[wr_slot] <= bus.din_q;
        end
    end

    assign bus.valid_out = valid_out_q;
    assign bus.sof_out   = sof_out_q;
    assign bus.err_sync  = err_sync_q;
    assign bus.do1_re    = do1_re_q;
    assign bus.do1_im    = do1_im_q;
    assign bus.do2_re    = do2_re_q;
    assign bus.do2_im    = do2_im_q;

endmodule

// File: tb/tb_bfly_r2_stage.sv
// Directed bench for bfly_r2_stage: a full-precision and a scaling instance
// (NUM=2, DATA=8) driven with identical beats and checked against
// hand-computed sum/difference values.
module tb_bfly_r2_stage;
    typedef logic signed [31:0] vec_t [11];

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    vec_t obs0, obs1;
    string names [11] = '{"valid_out", "sof_out", "err_sync",
                          "do1_re0", "do1_re1", "do2_re0", "do2_re1",
                          "do1_im0", "do1_im1", "do2_im0", "do2_im1"};

    bfly_r2_stage_if #(.IN_WIDTH(9), .NUM(2), .SCALE(0)) if0 ();
    bfly_r2_stage_if #(.IN_WIDTH(9), .NUM(2), .SCALE(1)) if1 ();

    bfly_r2_stage #(.IN_WIDTH(9), .NUM(2), .DATA(8), .SCALE(0)) dut0 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if0)
    );

    bfly_r2_stage #(.IN_WIDTH(9), .NUM(2), .DATA(8), .SCALE(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (if1)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Flatten both instances' outputs into signed words for comparison.
    always_comb begin
        obs0[0]  = {31'b0, if0.valid_out};
        obs0[1]  = {31'b0, if0.sof_out};
        obs0[2]  = {31'b0, if0.err_sync};
        obs0[3]  = 32'($signed(if0.do1_re[0]));
        obs0[4]  = 32'($signed(if0.do1_re[1]));
        obs0[5]  = 32'($signed(if0.do2_re[0]));
        obs0[6]  = 32'($signed(if0.do2_re[1]));
        obs0[7]  = 32'($signed(if0.do1_im[0]));
        obs0[8]  = 32'($signed(if0.do1_im[1]));
        obs0[9]  = 32'($signed(if0.do2_im[0]));
        obs0[10] = 32'($signed(if0.do2_im[1]));
        obs1[0]  = {31'b0, if1.valid_out};
        obs1[1]  = {31'b0, if1.sof_out};
        obs1[2]  = {31'b0, if1.err_sync};
        obs1[3]  = 32'($signed(if1.do1_re[0]));
        obs1[4]  = 32'($signed(if1.do1_re[1]));
        obs1[5]  = 32'($signed(if1.do2_re[0]));
        obs1[6]  = 32'($signed(if1.do2_re[1]));
        obs1[7]  = 32'($signed(if1.do1_im[0]));
        obs1[8]  = 32'($signed(if1.do1_im[1]));
        obs1[9]  = 32'($signed(if1.do2_im[0]));
        obs1[10] = 32'($signed(if1.do2_im[1]));
    end

    // Drive one beat into both instances, then sample 1 ns after the edge.
    task automatic apply_stimulus(input int v, input int s,
                                  input int r0, input int r1,
                                  input int i0, input int i1);
        if0.valid_in = v[0];
        if0.sof_in   = s[0];
        if0.din_i[0] = r0[8:0];
        if0.din_i[1] = r1[8:0];
        if0.din_q[0] = i0[8:0];
        if0.din_q[1] = i1[8:0];
        if1.valid_in = v[0];
        if1.sof_in   = s[0];
        if1.din_i[0] = r0[8:0];
        if1.din_i[1] = r1[8:0];
        if1.din_q[0] = i0[8:0];
        if1.din_q[1] = i1[8:0];
        @(posedge clk);
        #1;
    endtask

    // Compare the first n output fields of one instance against expectations.
    task automatic check_output(input int dut, input string tag,
                                input vec_t exp, input int n);
        logic signed [31:0] o;
        for (int i = 0; i < n; i++) begin
            o = (dut == 1) ? obs1[i] : obs0[i];
            checks++;
            assert (o === exp[i]) else begin
                errors++;
                $error("[TB] FAIL %s.%s (dut%0d): observed %0d expected %0d",
                       tag, names[i], dut, o, exp[i]);
            end
        end
    endtask

    // Directed sequence: reset, basic, stall, back-to-back, resync, reset mid-frame.
    initial begin
        int sr0 [4] = '{1, 3, 10, 30};
        int sr1 [4] = '{2, 4, 20, 40};

        rstn = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output(0, "reset", '{0,0,0,0,0,0,0,0,0,0,0}, 11);
        check_output(1, "reset", '{0,0,0,0,0,0,0,0,0,0,0}, 11);
        rstn = 1'b1;

        $display("[TB] basic frame");
        apply_stimulus(1, 1, 1, 2, 0, 0);
        check_output(0, "basic_b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 3, 4, 0, 0);
        check_output(0, "basic_b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 10, 20, 0, 0);
        check_output(0, "basic_o0", '{1,1,0,11,22,-9,-18,0,0,0,0}, 11);
        check_output(1, "basic_o0", '{1,1,0,6,11,-4,-9,0,0,0,0}, 11);
        apply_stimulus(1, 0, 30, 40, 0, 0);
        check_output(0, "basic_o1", '{1,0,0,33,44,-27,-36,0,0,0,0}, 11);
        check_output(1, "basic_o1", '{1,0,0,17,22,-13,-18,0,0,0,0}, 11);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output(0, "basic_hold", '{0,0,0,33,44,-27,-36,0,0,0,0}, 11);

        $display("[TB] stalled frame");
        for (int b = 0; b < 4; b++) begin
            apply_stimulus(1, (b == 0) ? 1 : 0, sr0[b], sr1[b], 0, 0);
            if (b == 2)
                check_output(0, "stall_o0", '{1,1,0,11,22,-9,-18,0,0,0,0}, 11);
            else if (b == 3)
                check_output(0, "stall_o1", '{1,0,0,33,44,-27,-36,0,0,0,0}, 11);
            else
                check_output(0, "stall_fill", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
            for (int g = 0; g < 3; g++) begin
                apply_stimulus(0, (g == 1) ? 1 : 0, 0, 0, 0, 0);
                check_output(0, "stall_gap", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
            end
        end

        $display("[TB] back-to-back frames");
        apply_stimulus(1, 1, 5, -7, 1, 2);
        check_output(0, "b2b_f1b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 100, -100, 3, 4);
        check_output(0, "b2b_f1b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, -5, 7, 10, 20);
        check_output(0, "b2b_f1o0", '{1,1,0,0,0,10,-14,11,22,-9,-18}, 11);
        apply_stimulus(1, 0, -100, 100, -30, -40);
        check_output(0, "b2b_f1o1", '{1,0,0,0,0,200,-200,-27,-36,33,44}, 11);
        apply_stimulus(1, 0, 255, -256, 0, 0);
        check_output(0, "b2b_f2b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, -256, 255, 0, 0);
        check_output(0, "b2b_f2b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 255, -256, 0, 0);
        check_output(0, "b2b_f2o0", '{1,1,0,510,-512,0,0,0,0,0,0}, 11);
        check_output(1, "sat_f2o0", '{1,1,0,255,-256,0,0,0,0,0,0}, 11);
        apply_stimulus(1, 0, 255, -256, 0, 0);
        check_output(0, "b2b_f2o1", '{1,0,0,-1,-1,-511,511,0,0,0,0}, 11);
        check_output(1, "sat_f2o1", '{1,0,0,0,0,-255,255,0,0,0,0}, 11);
        apply_stimulus(1, 1, 3, 0, 0, 0);
        check_output(0, "b2b_f3b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 1, 1, 0, 0);
        check_output(0, "b2b_f3b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output(0, "b2b_f3o0", '{1,1,0,3,0,3,0,0,0,0,0}, 11);
        check_output(1, "sat_f3o0", '{1,1,0,2,0,2,0,0,0,0,0}, 11);
        apply_stimulus(1, 0, -1, -1, 0, 0);
        check_output(0, "b2b_f3o1", '{1,0,0,0,0,2,2,0,0,0,0}, 11);
        check_output(1, "sat_f3o1", '{1,0,0,0,0,1,1,0,0,0,0}, 11);

        $display("[TB] resync");
        apply_stimulus(1, 1, 7, 8, 0, 0);
        check_output(0, "resync_b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 1, 1, 1, 0, 0);
        check_output(0, "resync_err", '{0,0,1,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 2, 2, 0, 0);
        check_output(0, "resync_b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 5, 6, 0, 0);
        check_output(0, "resync_o0", '{1,1,0,6,7,-4,-5,0,0,0,0}, 11);
        apply_stimulus(1, 0, 9, 9, 0, 0);
        check_output(0, "resync_o1", '{1,0,0,11,11,-7,-7,0,0,0,0}, 11);

        $display("[TB] reset mid-frame");
        apply_stimulus(1, 1, 1, 2, 0, 0);
        apply_stimulus(1, 0, 3, 4, 0, 0);
        apply_stimulus(1, 0, 10, 20, 0, 0);
        check_output(0, "rst_pre", '{1,1,0,11,22,-9,-18,0,0,0,0}, 11);
        rstn = 1'b0;
        apply_stimulus(1, 0, 30, 40, 0, 0);
        check_output(0, "rst_clear", '{0,0,0,0,0,0,0,0,0,0,0}, 11);
        check_output(1, "rst_clear", '{0,0,0,0,0,0,0,0,0,0,0}, 11);
        rstn = 1'b1;
        apply_stimulus(1, 0, 2, 2, 0, 0);
        check_output(0, "rst_b0", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 4, 4, 0, 0);
        check_output(0, "rst_b1", '{0,0,0,0,0,0,0,0,0,0,0}, 3);
        apply_stimulus(1, 0, 6, 6, 0, 0);
        check_output(0, "rst_o0", '{1,1,0,8,8,-4,-4,0,0,0,0}, 11);
        apply_stimulus(1, 0, 8, 8, 0, 0);
        check_output(0, "rst_o1", '{1,0,0,12,12,-4,-4,0,0,0,0}, 11);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output(0, "rst_idle", '{0,0,0,0,0,0,0,0,0,0,0}, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
